// File: rtl/ibex_cx_sequencer_pkg.sv
// rtl/ibex_cx_sequencer_pkg.sv - shared types for the eFPGA custom-instruction sequencer
package ibex_cx_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    DONE,
    DRAIN
  } cx_state_e;

  typedef enum logic [1:0] {
    CX_OP_0,
    CX_OP_1,
    CX_OP_2,
    CX_OP_3
  } cx_optype_e;

endpackage

// File: rtl/ibex_cx_sequencer.sv
// rtl/ibex_cx_sequencer.sv - sequences one eFPGA custom instruction between EX and the eFPGA
module ibex_cx_sequencer
  import ibex_cx_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        issue_i,
  input  logic        kill_i,
  input  logic [1:0]  cx_optype_i,
  input  logic [31:0] operand_a_i,
  input  logic [31:0] operand_b_i,
  output logic        cx_req_valid_o,
  input  logic        cx_req_ready_i,
  output logic [1:0]  cx_req_optype_o,
  output logic [31:0] cx_req_a_o,
  output logic [31:0] cx_req_b_o,
  input  logic        cx_resp_valid_i,
  input  logic [31:0] cx_resp_data_i,
  output logic        cx_resp_ready_o,
  output logic [31:0] result_o,
  output logic        done_o,
  output logic        timeout_o,
  output logic        busy_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  cx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  cx_optype_e       optype_q, optype_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [31:0]      result_q, result_d;
  logic             to_q, to_d;

  // Saturates at the compare value so a stalled count never wraps back into range.
  assign cnt_inc = (cnt_q == CNT_LAST) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    optype_d = optype_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    to_d     = to_q;

    unique case (state_q)
      IDLE: begin
        if (issue_i && !kill_i) begin
          optype_d = cx_optype_e'(cx_optype_i);
          a_d      = operand_a_i;
          b_d      = operand_b_i;
          state_d  = REQ;
        end
      end
      REQ: begin
        // Once the handshake completes the eFPGA owns the op, so a late kill must drain it.
        if (cx_req_ready_i) begin
          cnt_d   = '0;
          state_d = WAIT;
        end else if (kill_i) begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        cnt_d = cnt_inc;
        if (cx_resp_valid_i) begin
          result_d = cx_resp_data_i;
          to_d     = 1'b0;
          state_d  = DONE;
        end else if (kill_i) begin
          cnt_d   = '0;
          state_d = DRAIN;
        end else if (cnt_q == CNT_LAST) begin
          result_d = '0;
          to_d     = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        to_d    = 1'b0;
        state_d = IDLE;
      end
      DRAIN: begin
        cnt_d = cnt_inc;
        if (cx_resp_valid_i || (cnt_q == CNT_LAST)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      optype_q <= CX_OP_0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      optype_q <= optype_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      to_q     <= to_d;
    end
  end

  assign cx_req_valid_o  = (state_q == REQ);
  assign cx_resp_ready_o = (state_q == WAIT) || (state_q == DRAIN);
  assign done_o          = (state_q == DONE);
  assign timeout_o       = (state_q == DONE) && to_q;
  assign busy_o          = (state_q != IDLE);
  assign cx_req_optype_o = optype_q;
  assign cx_req_a_o      = a_q;
  assign cx_req_b_o      = b_q;
  assign result_o        = result_q;

endmodule

// File: tb/tb_ibex_cx_sequencer.sv
// tb/tb_ibex_cx_sequencer.sv - bench for ibex_cx_sequencer against a per-op timeline model
module tb_ibex_cx_sequencer;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        issue_i = 1'b0, kill_i = 1'b0;
  logic [1:0]  cx_optype_i = '0;
  logic [31:0] operand_a_i = '0, operand_b_i = '0;
  logic        cx_req_valid_o, cx_req_ready_i = 1'b0;
  logic [1:0]  cx_req_optype_o;
  logic [31:0] cx_req_a_o, cx_req_b_o;
  logic        cx_resp_valid_i = 1'b0;
  logic [31:0] cx_resp_data_i = '0;
  logic        cx_resp_ready_o;
  logic [31:0] result_o;
  logic        done_o, timeout_o, busy_o;

  ibex_cx_sequencer #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .issue_i(issue_i), .kill_i(kill_i),
    .cx_optype_i(cx_optype_i), .operand_a_i(operand_a_i), .operand_b_i(operand_b_i),
    .cx_req_valid_o(cx_req_valid_o), .cx_req_ready_i(cx_req_ready_i),
    .cx_req_optype_o(cx_req_optype_o), .cx_req_a_o(cx_req_a_o), .cx_req_b_o(cx_req_b_o),
    .cx_resp_valid_i(cx_resp_valid_i), .cx_resp_data_i(cx_resp_data_i),
    .cx_resp_ready_o(cx_resp_ready_o), .result_o(result_o), .done_o(done_o),
    .timeout_o(timeout_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Per-cycle stimulus and expected outputs of one op, indexed from the IDLE cycle that issues it.
  logic        iss[64], kil[64], rdy[64], rv[64];
  logic [31:0] rd[64], opa[64], opb[64];
  logic [1:0]  opt[64];
  logic        ev[64], er[64], ed[64], eto[64], eb[64];

  // mode 0: response after l WAIT cycles; 1: no response (timeout); 2: kill while IDLE;
  // mode 3: kill in REQ cycle k with ready low; 4: kill at WAIT count k, drain response at m (m==T: none)
  task automatic run_op(input int mode, input int r, input int l, input int k, input int m,
                        input logic [31:0] data, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b);
    int n, h, d, kc, ds, en;
    logic [31:0] exp_res;
    exp_res = '0;
    for (int i = 0; i < 64; i++) begin
      iss[i] = 0; kil[i] = 0; rdy[i] = 0; rv[i] = 0; rd[i] = $urandom;
      opa[i] = $urandom; opb[i] = $urandom; opt[i] = 2'($urandom);
      ev[i] = 0; er[i] = 0; ed[i] = 0; eto[i] = 0; eb[i] = 0;
    end
    opa[0] = a; opb[0] = b; opt[0] = op;
    h = 1 + r;
    n = 1;
    case (mode)
      0, 1: begin
        d = (mode == 0) ? h + 2 + l : h + T + 1;
        n = d + 1;
        for (int i = 0; i <= d; i++) iss[i] = 1;
        for (int i = h + 1; i <= d; i++) rdy[i] = 1'($urandom);
        rdy[h] = 1;
        if (mode == 0) begin
          rv[h + 1 + l] = 1;
          rd[h + 1 + l] = data;
          exp_res = data;
        end
        for (int i = 1; i <= h; i++) ev[i] = 1;
        for (int i = h + 1; i < d; i++) er[i] = 1;
        for (int i = 1; i <= d; i++) eb[i] = 1;
        ed[d] = 1;
        eto[d] = (mode == 1);
        kil[d] = 1'($urandom);
      end
      2: begin
        iss[0] = 1; kil[0] = 1;
      end
      3: begin
        n = k + 1;
        for (int i = 0; i <= k; i++) iss[i] = 1;
        kil[k] = 1;
        for (int i = 1; i <= k; i++) begin ev[i] = 1; eb[i] = 1; end
      end
      default: begin
        kc = h + 1 + k;
        ds = kc + 1;
        en = (m < T) ? ds + m + 1 : ds + T;
        n = en;
        for (int i = 0; i <= kc; i++) iss[i] = 1;
        for (int i = ds; i < en; i++) begin iss[i] = 1'($urandom); kil[i] = 1'($urandom); end
        kil[kc] = 1;
        rdy[h] = 1;
        if (m < T) begin rv[ds + m] = 1; rd[ds + m] = data; end
        for (int i = 1; i <= h; i++) ev[i] = 1;
        for (int i = h + 1; i < en; i++) er[i] = 1;
        for (int i = 1; i < en; i++) eb[i] = 1;
      end
    endcase
    for (int i = 0; i < n; i++) begin
      issue_i = iss[i]; kill_i = kil[i]; cx_req_ready_i = rdy[i];
      cx_resp_valid_i = rv[i]; cx_resp_data_i = rd[i];
      cx_optype_i = opt[i]; operand_a_i = opa[i]; operand_b_i = opb[i];
      @(negedge clk);
      chk($sformatf("m%0d c%0d req_valid", mode, i), 32'(cx_req_valid_o), 32'(ev[i]));
      chk($sformatf("m%0d c%0d resp_ready", mode, i), 32'(cx_resp_ready_o), 32'(er[i]));
      chk($sformatf("m%0d c%0d done", mode, i), 32'(done_o), 32'(ed[i]));
      chk($sformatf("m%0d c%0d timeout", mode, i), 32'(timeout_o), 32'(eto[i]));
      chk($sformatf("m%0d c%0d busy", mode, i), 32'(busy_o), 32'(eb[i]));
      if (ev[i]) begin
        chk($sformatf("m%0d c%0d req_optype", mode, i), 32'(cx_req_optype_o), 32'(op));
        chk($sformatf("m%0d c%0d req_a", mode, i), cx_req_a_o, a);
        chk($sformatf("m%0d c%0d req_b", mode, i), cx_req_b_o, b);
      end
      if (ed[i]) chk($sformatf("m%0d c%0d result", mode, i), result_o, exp_res);
      @(posedge clk); #1;
    end
    issue_i = 0; kill_i = 0; cx_req_ready_i = 0; cx_resp_valid_i = 0;
  endtask

  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      issue_i = 0; kill_i = 1'($urandom); cx_resp_valid_i = 0; cx_req_ready_i = 1'($urandom);
      @(negedge clk);
      chk("gap busy", 32'(busy_o), 32'(0));
      chk("gap done", 32'(done_o), 32'(0));
      chk("gap req_valid", 32'(cx_req_valid_o), 32'(0));
      @(posedge clk); #1;
    end
    kill_i = 0; cx_req_ready_i = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " req_valid"}, 32'(cx_req_valid_o), 32'(0));
    chk({tag, " resp_ready"}, 32'(cx_resp_ready_o), 32'(0));
    chk({tag, " done"}, 32'(done_o), 32'(0));
    chk({tag, " timeout"}, 32'(timeout_o), 32'(0));
    chk({tag, " busy"}, 32'(busy_o), 32'(0));
    chk({tag, " result"}, result_o, 32'(0));
    chk({tag, " req_a"}, cx_req_a_o, 32'(0));
    chk({tag, " req_b"}, cx_req_b_o, 32'(0));
    chk({tag, " req_optype"}, 32'(cx_req_optype_o), 32'(0));
  endtask

  initial begin
    int mode, r, k;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1;
    @(posedge clk); #1;

    run_op(0, 0, 2, 0, 0, 32'h0000_000C, 2'd2, 32'd5, 32'd7);
    run_op(0, 4, 1, 0, 0, 32'h1234_5678, 2'd1, 32'hDEAD_BEEF, 32'hCAFE_F00D);
    run_op(1, 1, 0, 0, 0, 32'h0, 2'd3, 32'h11, 32'h22);
    run_op(4, 0, 0, 2, 2, 32'h0000_00AA, 2'd0, 32'h33, 32'h44);
    run_op(0, 0, T - 1, 0, 0, 32'h5555_AAAA, 2'd2, 32'h55, 32'h66);
    run_op(2, 0, 0, 0, 0, 32'h0, 2'd1, 32'h77, 32'h88);
    run_op(3, 2, 0, 2, 0, 32'h0, 2'd3, 32'h99, 32'hAA);
    run_op(4, 1, 0, T - 1, T, 32'hBEEF, 2'd1, 32'hBB, 32'hCC);
    idle_gap(2);

    for (int t = 0; t < 60; t++) begin
      mode = $urandom_range(0, 4);
      r = $urandom_range(0, 3);
      k = (mode == 3) ? $urandom_range(1, r + 1) : $urandom_range(0, T - 1);
      run_op(mode, r, $urandom_range(0, T - 1), k, $urandom_range(0, T),
             $urandom, 2'($urandom), $urandom, $urandom);
      if ($urandom_range(0, 3) == 0) idle_gap($urandom_range(1, 2));
    end

    // Asynchronous reset while a request is outstanding.
    run_op(0, 0, 0, 0, 0, 32'hFACE_0001, 2'd1, 32'h1, 32'h2);
    issue_i = 1; cx_optype_i = 2'd3; operand_a_i = 32'hA5A5_A5A5; operand_b_i = 32'h5A5A_5A5A;
    @(posedge clk); #1;
    cx_req_ready_i = 1;
    @(posedge clk); #1;
    cx_req_ready_i = 0;
    @(posedge clk); #1;
    chk("pre-reset resp_ready", 32'(cx_resp_ready_o), 32'(1));
    #2 rst_n = 0;
    #1 chk_all_zero("async reset");
    issue_i = 0;
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk);
    chk("post-reset busy", 32'(busy_o), 32'(0));
    chk("post-reset req_valid", 32'(cx_req_valid_o), 32'(0));
    @(posedge clk); #1;
    @(negedge clk);
    chk("post-reset idle busy", 32'(busy_o), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
